// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_unit_pkg
//  Shared definitions for the program-counter unit and its return stack:
//  default widths, the PC reset vector, the per-cycle operation encoding and
//  the strobe-to-operation priority decode.
// ---------------------------------------------------------------------------
package pc_unit_pkg;

   localparam int ADDR_W_DEF      = 8;
   localparam int STACK_DEPTH_DEF = 4;

   // PC value loaded by reset; cast to the instance width where used.
   localparam int PC_RESET_VEC    = 0;

   // The single action the unit takes in a given cycle.
   typedef enum logic [2:0] {
      OP_HOLD     = 3'd0,
      OP_INC      = 3'd1,
      OP_LOAD     = 3'd2,
      OP_CALL     = 3'd3,
      OP_RET      = 3'd4,
      OP_CONFLICT = 3'd5
   } pc_op_e;

   // Collapses the decoder strobes into one operation, highest priority first.
   // pc_inc is routinely high together with call/ret; call/ret win silently.
   function automatic pc_op_e decode_op(input logic call,
                                        input logic ret,
                                        input logic pc_load,
                                        input logic pc_inc);
      if (call && ret) return OP_CONFLICT;
      if (ret)         return OP_RET;
      if (call)        return OP_CALL;
      if (pc_load)     return OP_LOAD;
      if (pc_inc)      return OP_INC;
      return OP_HOLD;
   endfunction

endpackage : pc_unit_pkg

// File: rtl/pc_unit_ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
//  Bounded LIFO of return addresses with its stack pointer. No priority or
//  error handling lives here: a push while full or a pop while empty is
//  simply ignored, and the parent never asserts push and pop together.
//
//  Ports
//   clk    in   1        rising-edge clock
//   reset  in   1        asynchronous active-high reset (clears sp only)
//   push   in   1        write din at sp, sp <= sp+1
//   pop    in   1        sp <= sp-1 (top entry is already on dout)
//   din    in   ADDR_W   address to push
//   dout   out  ADDR_W   current top entry (stack[sp-1]); 0 when empty
//   full   out  1        sp == DEPTH
//   empty  out  1        sp == 0
// ---------------------------------------------------------------------------
module ret_stack
   import pc_unit_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = STACK_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int SP_W  = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [SP_W-1:0]   sp_q;
   logic [SP_W-1:0]   sp_d;
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              do_push;
   logic              do_pop;

   assign full    = (sp_q == SP_W'(DEPTH));
   assign empty   = (sp_q == '0);

   assign do_push = push && !full;
   assign do_pop  = pop  && !empty;

   // Truncation is safe: wr_idx is only used when not full, top_idx only
   // when not empty, so both stay inside 0..DEPTH-1 whenever they matter.
   assign wr_idx  = IDX_W'(sp_q);
   assign top_idx = IDX_W'(sp_q - SP_W'(1));

   assign dout    = empty ? '0 : mem_q[top_idx];

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      sp_d = sp_q;
      if (do_push) begin
         sp_d = sp_q + SP_W'(1);
      end else if (do_pop) begin
         sp_d = sp_q - SP_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // NOTE: the storage array is deliberately left out of reset; entries above
   // sp are never observed, so clearing them would only cost a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= din;
      end
   end

endmodule : ret_stack

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//  Program counter that sits right after the instruction decoder. Each cycle
//  the decoder strobes are reduced to one operation (conflict, return, call,
//  load, increment, hold, in that priority) which updates the PC, the
//  return-address stack and a sticky error flag on the rising clock edge.
//  The unit keeps executing legal operations after an error.
//
//  Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous active-high reset
//   pc_inc       in   1        advance PC by one
//   pc_load      in   1        PC <= target (JMP / taken JEQ)
//   call         in   1        JMS: push PC+1, PC <= target
//   ret          in   1        BBL: PC <= popped return address
//   target       in   ADDR_W   jump / call destination
//   pc           out  ADDR_W   current program counter (registered)
//   stack_full   out  1        all STACK_DEPTH entries valid
//   stack_empty  out  1        no entries valid
//   stack_err    out  1        sticky overflow / underflow / call-ret conflict
// ---------------------------------------------------------------------------
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_inc,
   input  logic              pc_load,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic              stack_full,
   output logic              stack_empty,
   output logic              stack_err
);

   pc_op_e            op;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_d;
   logic              err_q;
   logic              err_d;
   logic [ADDR_W-1:0] pc_plus1;
   logic              stk_push;
   logic              stk_pop;
   logic [ADDR_W-1:0] stk_top;
   logic              stk_full;
   logic              stk_empty;

   assign op       = decode_op(call, ret, pc_load, pc_inc);

   // Natural ADDR_W-bit wrap: both the increment and the pushed return
   // address roll over from all-ones to zero without any special case.
   assign pc_plus1 = pc_q + ADDR_W'(1);

   always_comb begin
      pc_d     = pc_q;
      err_d    = err_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      unique case (op)
         OP_CONFLICT: begin
            err_d = 1'b1;
         end
         OP_RET: begin
            if (stk_empty) begin
               err_d = 1'b1;
            end else begin
               pc_d    = stk_top;
               stk_pop = 1'b1;
            end
         end
         OP_CALL: begin
            // Overflow aborts the whole call: no push and no jump.
            if (stk_full) begin
               err_d = 1'b1;
            end else begin
               stk_push = 1'b1;
               pc_d     = target;
            end
         end
         OP_LOAD: pc_d = target;
         OP_INC:  pc_d = pc_plus1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= ADDR_W'(PC_RESET_VEC);
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   ret_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (pc_plus1),
      .dout  (stk_top),
      .full  (stk_full),
      .empty (stk_empty)
   );

   assign pc          = pc_q;
   assign stack_full  = stk_full;
   assign stack_empty = stk_empty;
   assign stack_err   = err_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//  Scoreboard bench for pc_unit. The driver applies strobes on the falling
//  edge, runs a behavioural model (PC integer plus a queue used as the
//  return stack) and pushes the expected post-edge state. A monitor samples
//  the DUT 1 time unit after each rising edge and pops one expectation.
// ---------------------------------------------------------------------------
module tb_pc_unit;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0] pc;
      logic       full;
      logic       empty;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       pc_inc, pc_load, call, ret;
   logic [7:0] target;
   logic [7:0] pc;
   logic       stack_full, stack_empty, stack_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int         m_pc;
   logic [7:0] m_stk[$];
   logic       m_err;
   exp_t       exp_q[$];

   pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .call        (call),
      .ret         (ret),
      .target      (target),
      .pc          (pc),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_state(input string tag, input exp_t e);
      check({tag, ".pc"},    int'(pc),          int'(e.pc));
      check({tag, ".full"},  int'(stack_full),  int'(e.full));
      check({tag, ".empty"}, int'(stack_empty), int'(e.empty));
      check({tag, ".err"},   int'(stack_err),   int'(e.err));
   endtask

   function automatic exp_t model_state();
      exp_t e;
      e.pc    = m_pc[7:0];
      e.full  = (m_stk.size() == DEPTH);
      e.empty = (m_stk.size() == 0);
      e.err   = m_err;
      return e;
   endfunction

   function automatic void model_reset();
      m_pc  = 0;
      m_stk.delete();
      m_err = 1'b0;
   endfunction

   // Spec rules applied directly to the model state.
   function automatic void model_step(input logic c, input logic r, input logic ld,
                                      input logic inc, input logic [7:0] t);
      if (c && r) begin
         m_err = 1'b1;
      end else if (r) begin
         if (m_stk.size() == 0) m_err = 1'b1;
         else                   m_pc = int'(m_stk.pop_back());
      end else if (c) begin
         if (m_stk.size() == DEPTH) begin
            m_err = 1'b1;
         end else begin
            m_stk.push_back(8'((m_pc + 1) % 256));
            m_pc = int'(t);
         end
      end else if (ld) begin
         m_pc = int'(t);
      end else if (inc) begin
         m_pc = (m_pc + 1) % 256;
      end
   endfunction

   // One clock of stimulus: drive on the falling edge, predict, enqueue.
   task automatic drive(input logic c, input logic r, input logic ld,
                        input logic inc, input logic [7:0] t);
      @(negedge clk);
      call    = c;
      ret     = r;
      pc_load = ld;
      pc_inc  = inc;
      target  = t;
      model_step(c, r, ld, inc, t);
      exp_q.push_back(model_state());
   endtask

   // Reset asserted in the middle of the low phase; outputs must clear
   // before any further clock edge.
   task automatic async_reset();
      @(negedge clk);
      {call, ret, pc_load, pc_inc} = 4'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_state("async_reset", model_state());
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Monitor: one expectation per driven cycle, sampled after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) check_state("cycle", exp_q.pop_front());
      end
   end

   initial begin
      reset   = 1'b1;
      {call, ret, pc_load, pc_inc} = 4'b0;
      target  = 8'h00;
      model_reset();
      #1;
      check_state("por", model_state());
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // 1: plain increments
      repeat (3) drive(0, 0, 0, 1, 8'h00);

      // 2: call with pc_inc also high, then return
      drive(0, 0, 1, 0, 8'h10);
      drive(1, 0, 0, 1, 8'h40);
      drive(0, 1, 0, 1, 8'h00);

      // 3: fill the stack, overflow, unwind in LIFO order
      drive(1, 0, 0, 1, 8'h50);
      drive(1, 0, 0, 1, 8'h60);
      drive(1, 0, 0, 1, 8'h70);
      drive(1, 0, 0, 1, 8'h78);
      drive(1, 0, 0, 1, 8'h80);
      repeat (4) drive(0, 1, 0, 1, 8'h00);

      // 4: underflow holds PC, later ops still execute
      async_reset();
      drive(0, 0, 1, 0, 8'h22);
      drive(0, 1, 0, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h00);

      // 5: wrap of PC and of the pushed return address
      drive(0, 0, 1, 0, 8'hFF);
      drive(0, 0, 0, 1, 8'h00);
      drive(0, 0, 1, 0, 8'hFF);
      drive(1, 0, 0, 1, 8'h05);
      drive(0, 1, 0, 0, 8'h00);

      // 6: call/ret conflict, then async reset with sp=2, pc=0x33
      async_reset();
      drive(1, 0, 0, 0, 8'h20);
      drive(1, 0, 0, 0, 8'h33);
      drive(1, 1, 0, 1, 8'h99);
      async_reset();

      // Randomised traffic with an occasional mid-run reset
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (i % 200 == 199) begin
            async_reset();
         end else if (r < 4) begin
            drive(1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
         end else if (r < 8) begin
            drive(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
         end else if (r == 8) begin
            drive(1, 1, 0, 1, 8'($urandom));
         end else if (r < 11) begin
            drive(0, 0, 1, $urandom_range(0, 1) == 1, 8'($urandom));
         end else if (r < 17) begin
            drive(0, 0, 0, 1, 8'($urandom));
         end else begin
            drive(0, 0, 0, 0, 8'($urandom));
         end
      end

      // Drain the scoreboard within a bounded number of cycles
      @(negedge clk);
      {call, ret, pc_load, pc_inc} = 4'b0;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pc_unit
